// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: FSM state encoding, bubble encoding
// and default register-address width.
package pipe_pkg;

    // Default register-address width (32 architectural registers).
    localparam int REG_AW_DEF = 5;

    // A bubble is an all-zeros pipeline-register image (decodes as a NOP).
    localparam logic [31:0] BUBBLE_INSN = 32'h0000_0000;

    // Hazard-controller FSM states; encoding 2'd3 is unused and treated as ERROR.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Pure combinational hazard decode: load-use dependency and memory stall.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_req,
    input  logic              dmem_ready,
    output logic              load_use,
    output logic              mem_stall
);

    logic rs1_hit;
    logic rs2_hit;

    // Register 0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign rs1_hit   = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit   = id_use_rs2 && (id_rs2 == ex_rd);
    assign load_use  = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
    assign mem_stall = mem_req && !dmem_ready;

endmodule

// File: rtl/hazard_seq_ctrl.sv
// Pipeline hazard sequencer: stalls on memory waits and load-use hazards,
// flushes on taken branches, and locks into ERROR on a memory-wait timeout.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_seq_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_br_taken,
    input  logic              mem_req,
    input  logic              dmem_ready,
    output logic              pc_we,
    output logic              if_id_we,
    output logic              id_ex_we,
    output logic              ex_mem_we,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic [1:0]        state_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    ctrl_state_t state;
    logic [7:0]  wait_cnt;
    logic        err_q;
    logic        load_use;
    logic        mem_stall;
    logic        active;

    hazard_detect #(.REG_AW(REG_AW)) u_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .mem_req     (mem_req),
        .dmem_ready  (dmem_ready),
        .load_use    (load_use),
        .mem_stall   (mem_stall)
    );

    // Hazard decode only matters in RUN/MEM_WAIT and outside reset.
    assign active = !reset && (state == ST_RUN || state == ST_MEM_WAIT);

    // State, wait counter and sticky error; a saturated wait at the limit locks into ERROR.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            wait_cnt <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_RUN, ST_MEM_WAIT: begin
                    if (mem_stall) begin
                        if (wait_cnt >= WAIT_LIM) begin
                            state <= ST_ERROR;
                            err_q <= 1'b1;
                        end else begin
                            state    <= ST_MEM_WAIT;
                            wait_cnt <= (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
                        end
                    end else begin
                        state    <= ST_RUN;
                        wait_cnt <= 8'd0;
                    end
                end
                default: begin
                    state <= ST_ERROR;
                    err_q <= 1'b1;
                end
            endcase
        end
    end

    // Zero-latency enable/flush muxing: reset, mem_stall, branch, load-use, normal.
    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_we    = 1'b0;
        ex_mem_we   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (reset) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (active && !mem_stall) begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
            if (ex_br_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_we       = 1'b0;
                if_id_we    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    assign state_o = state;
    assign err_o   = err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic stall_evt;
    logic flush_evt;

    // A discarded load-use (branch in the same cycle) does not count as a stall.
    assign stall_evt = active && (mem_stall || (load_use && !ex_br_taken));
    assign flush_evt = active && !mem_stall && ex_br_taken;

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_evt && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_seq_ctrl.sv
// Directed self-checking bench for hazard_seq_ctrl (default parameters).
module tb_hazard_seq_ctrl;

    localparam logic [5:0] C_NORMAL = 6'b111100;
    localparam logic [5:0] C_HOLD   = 6'b000000;
    localparam logic [5:0] C_BRANCH = 6'b111111;
    localparam logic [5:0] C_LUSE   = 6'b001101;
    localparam logic [5:0] C_RESET  = 6'b000011;
`ifdef HAZARD_PERF_CNT_EN
    localparam logic [31:0] EXP_STALL = 32'd2;
    localparam logic [31:0] EXP_FLUSH = 32'd1;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
    localparam logic [31:0] EXP_FLUSH = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken, mem_req, dmem_ready;
    logic        pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush;
    logic [1:0]  state_o;
    logic        err_o;
    logic [31:0] stall_cnt, flush_cnt;
    logic [5:0]  ctl;

    int n_checks = 0;
    int n_fail   = 0;

    assign ctl = {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush};

    hazard_seq_ctrl dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
        .mem_req(mem_req), .dmem_ready(dmem_ready),
        .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .state_o(state_o), .err_o(err_o), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_mem_read = 0;
        ex_br_taken = 0; mem_req = 0; dmem_ready = 1;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs(); mem_req = 1; dmem_ready = 0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (ctl !== C_RESET) begin n_fail++; $display("FAIL reset_ctl got %b want %b", ctl, C_RESET); end
        n_checks++;
        if (state_o !== 2'd0 || err_o !== 1'b0) begin n_fail++; $display("FAIL reset_state got %0d/%b want 0/0", state_o, err_o); end
        n_checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
        @(negedge clk); reset = 0; idle_inputs(); #1;
        n_checks++;
        if (ctl !== C_NORMAL) begin n_fail++; $display("FAIL post_reset_ctl got %b want %b", ctl, C_NORMAL); end
    endtask

    task automatic test_load_use();
        @(negedge clk); ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1; #1;
        n_checks++;
        if (ctl !== C_LUSE) begin n_fail++; $display("FAIL luse_rs1 got %b want %b", ctl, C_LUSE); end
        @(negedge clk); ex_mem_read = 0; #1;
        n_checks++;
        if (ctl !== C_NORMAL) begin n_fail++; $display("FAIL luse_bubble_done got %b want %b", ctl, C_NORMAL); end
        @(negedge clk); idle_inputs(); ex_mem_read = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1; id_rs1 = 5'd3; id_use_rs1 = 1; #1;
        n_checks++;
        if (ctl !== C_LUSE) begin n_fail++; $display("FAIL luse_rs2 got %b want %b", ctl, C_LUSE); end
        @(negedge clk); id_use_rs2 = 0; id_rs1 = 5'd7; id_use_rs1 = 0; #1;
        n_checks++;
        if (ctl !== C_NORMAL) begin n_fail++; $display("FAIL luse_unused_src got %b want %b", ctl, C_NORMAL); end
    endtask

    task automatic test_rd_zero();
        @(negedge clk); idle_inputs(); ex_mem_read = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1; #1;
        n_checks++;
        if (ctl !== C_NORMAL) begin n_fail++; $display("FAIL rd_zero got %b want %b", ctl, C_NORMAL); end
    endtask

    task automatic test_branch();
        @(negedge clk); idle_inputs(); ex_br_taken = 1; ex_mem_read = 1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1; #1;
        n_checks++;
        if (ctl !== C_BRANCH) begin n_fail++; $display("FAIL branch_over_luse got %b want %b", ctl, C_BRANCH); end
        @(negedge clk); idle_inputs(); #1;
        n_checks++;
        if (state_o !== 2'd0) begin n_fail++; $display("FAIL branch_state got %0d want 0", state_o); end
        n_checks++;
        if (stall_cnt !== EXP_STALL || flush_cnt !== EXP_FLUSH) begin
            n_fail++; $display("FAIL perf_cnt got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, EXP_STALL, EXP_FLUSH);
        end
    endtask

    task automatic test_mem_wait();
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); idle_inputs(); mem_req = 1; dmem_ready = 0; ex_br_taken = (i == 2); #1;
            n_checks++;
            if (ctl !== C_HOLD) begin n_fail++; $display("FAIL mem_stall_ctl[%0d] got %b want %b", i, ctl, C_HOLD); end
            n_checks++;
            if (state_o !== ((i == 1) ? 2'd0 : 2'd1)) begin n_fail++; $display("FAIL mem_stall_state[%0d] got %0d", i, state_o); end
        end
        @(negedge clk); idle_inputs(); mem_req = 1; dmem_ready = 1; #1;
        n_checks++;
        if (ctl !== C_NORMAL || state_o !== 2'd1) begin n_fail++; $display("FAIL mem_ready got %b/%0d want %b/1", ctl, state_o, C_NORMAL); end
        @(negedge clk); idle_inputs(); #1;
        n_checks++;
        if (state_o !== 2'd0) begin n_fail++; $display("FAIL mem_back_run got %0d want 0", state_o); end
    endtask

    task automatic test_reset_mid_wait();
        repeat (2) begin
            @(negedge clk); idle_inputs(); mem_req = 1; dmem_ready = 0;
        end
        @(negedge clk); reset = 1; #1;
        n_checks++;
        if (ctl !== C_RESET) begin n_fail++; $display("FAIL reset_in_wait got %b want %b", ctl, C_RESET); end
        @(negedge clk); reset = 0; idle_inputs(); #1;
        n_checks++;
        if (ctl !== C_NORMAL || state_o !== 2'd0) begin n_fail++; $display("FAIL after_wait_reset got %b/%0d want %b/0", ctl, state_o, C_NORMAL); end
    endtask

    task automatic test_timeout();
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk); idle_inputs(); mem_req = 1; dmem_ready = 0; #1;
            n_checks++;
            if (ctl !== C_HOLD || state_o !== ((i == 1) ? 2'd0 : 2'd1) || err_o !== 1'b0) begin
                n_fail++; $display("FAIL timeout_wait[%0d] got %b/%0d/%b", i, ctl, state_o, err_o);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle_inputs(); #1;
            n_checks++;
            if (state_o !== 2'd2 || err_o !== 1'b1 || ctl !== C_HOLD) begin
                n_fail++; $display("FAIL error_sticky[%0d] got %0d/%b/%b want 2/1/%b", i, state_o, err_o, ctl, C_HOLD);
            end
        end
        @(negedge clk); reset = 1; #1;
        n_checks++;
        if (ctl !== C_RESET) begin n_fail++; $display("FAIL reset_in_error got %b want %b", ctl, C_RESET); end
        @(negedge clk); reset = 0; #1;
        n_checks++;
        if (state_o !== 2'd0 || err_o !== 1'b0 || ctl !== C_NORMAL) begin
            n_fail++; $display("FAIL error_cleared got %0d/%b/%b want 0/0/%b", state_o, err_o, ctl, C_NORMAL);
        end
        n_checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin n_fail++; $display("FAIL cnt_cleared got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_rd_zero();
        test_branch();
        test_mem_wait();
        test_reset_mid_wait();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_seq_ctrl.md
HAZARD_SEQ_CTRL -- requirements
Module: hazard_seq_ctrl

Interface
REQ-001 Parameter REG_AW, 5, register-address width.
REQ-002 Parameter WAIT_MAX, 15, memory-wait cycles before timeout error; legal range 1..255.
REQ-003 Parameter CNT_W, 32, width of performance counters.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 id_rs1, id_rs2  in  REG_AW  source registers of instruction held in IF/ID.
REQ-007 id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2.
REQ-008 ex_mem_read  in  1  instruction in EX is a load.
REQ-009 ex_rd  in  REG_AW  destination register of instruction in EX.
REQ-010 ex_br_taken  in  1  branch/jump in EX resolved taken.
REQ-011 mem_req  in  1  MEM stage issuing a data-memory access.
REQ-012 dmem_ready  in  1  data memory completes access this cycle.
REQ-013 pc_we, if_id_we, id_ex_we, ex_mem_we  out  1 each  pipeline-register write enables.
REQ-014 if_id_flush, id_ex_flush  out  1 each  load a bubble (all zeros) into IF/ID, ID/EX.
REQ-015 state_o  out  2  current FSM state; err_o  out  1  sticky timeout error.
REQ-016 stall_cnt, flush_cnt  out  CNT_W each  performance counters (see Configuration).

Function
REQ-017 FSM states: RUN=0, MEM_WAIT=1, ERROR=2; encoding 3 unused and SHALL map to ERROR.
REQ-018 mem_stall = mem_req && !dmem_ready; evaluated combinationally in RUN and MEM_WAIT.
REQ-019 load_use = ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
REQ-020 Priority, highest first: ERROR, mem_stall, ex_br_taken, load_use, normal.
REQ-021 mem_stall (RUN or MEM_WAIT): all four write enables 0, both flushes 0; next state MEM_WAIT.
REQ-022 ex_br_taken without mem_stall: all write enables 1, if_id_flush=1, id_ex_flush=1, same cycle (zero latency); a coincident load_use is discarded.
REQ-023 load_use only: pc_we=0, if_id_we=0, id_ex_flush=1, id_ex_we=1, ex_mem_we=1; exactly one bubble per hazard.
REQ-024 Normal: all write enables 1, both flushes 0.
REQ-025 MEM_WAIT: wait counter increments each cycle mem_stall holds; on dmem_ready return to RUN, counter cleared, and REQ-022..024 apply in that same cycle.
REQ-026 Wait counter reaching WAIT_MAX while mem_stall SHALL enter ERROR next edge.
REQ-027 ERROR: all write enables 0, flushes 0, err_o=1; exited only by reset.
REQ-028 Wait counter is 8 bits and SHALL saturate, never wrap.

Reset
REQ-029 reset high at a rising edge: state RUN, wait counter 0, err_o 0, stall_cnt 0, flush_cnt 0.
REQ-030 While reset is high: all write enables 0, if_id_flush=1, id_ex_flush=1, regardless of state.
REQ-031 Reset asserted mid-MEM_WAIT or in ERROR SHALL abandon the wait with no residual stall.

Configuration
REQ-032 Macro HAZARD_PERF_CNT_EN defined: stall_cnt increments on each load_use or mem_stall cycle, flush_cnt on each branch flush; both saturate at all-ones.
REQ-033 Macro undefined: counters are not built, stall_cnt and flush_cnt tie to 0; ports unchanged.

Structure
REQ-034 Shared package pipe_pkg holds the FSM state enum, bubble encoding constant and REG_AW default.
REQ-035 Sub-module hazard_detect (pure combinational load_use/mem_stall decode) instantiated once; FSM, counters and output muxing in top.

Verification
REQ-036 ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle pc_we=0, if_id_we=0, id_ex_flush=1; next cycle (ex_mem_read=0) all enables 1.
REQ-037 ex_rd=0 with matching id_rs1=0 -> no stall.
REQ-038 ex_br_taken=1 coincident with load_use -> if_id_flush=id_ex_flush=1, pc_we=1, no stall.
REQ-039 mem_req=1, dmem_ready low 3 cycles -> state_o=1, enables 0 for 3 cycles; ready on 4th -> RUN, enables 1.
REQ-040 dmem_ready held low 16 cycles with WAIT_MAX=15 -> err_o=1, state_o=2, sticky until reset pulse.
REQ-041 With HAZARD_PERF_CNT_EN: 2 load-use hazards and 1 branch -> stall_cnt=2, flush_cnt=1; without macro both 0.
